// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from the EX result and MEM load data.
// Bubbles on load-use stalls and flushes; tracks stall and forwarding perf counters.
module ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             fwd_ex_ex1,
  input  logic             fwd_ex_ex2,
  input  logic             fwd_mem_ex1,
  input  logic             fwd_mem_ex2,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_alu_src,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             out_valid,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  output logic [XLEN-1:0]  store_data,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  typedef enum logic [1:0] {SEL_NONE, SEL_EX, SEL_MEM} sel_t;

  logic            vld_p0;
  logic [XLEN-1:0] rs1_p0, rs2_p0, imm_p0;
  logic [4:0]      rd_p0;
  logic            reg_write_p0, mem_read_p0, mem_write_p0, alu_src_p0;
  sel_t            sel1_p0, sel2_p0;
  logic            pend1, pend2;
  logic [XLEN-1:0] ex_last, mem_last;
  sel_t            sel1_nxt, sel2_nxt;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [XLEN-1:0] pick(input sel_t s, input logic [XLEN-1:0] ex_v,
                                           input logic [XLEN-1:0] mem_v, input logic [XLEN-1:0] reg_v);
    case (s)
      SEL_EX:  return ex_v;
      SEL_MEM: return mem_v;
      default: return reg_v;
    endcase
  endfunction

  // A MEM forward owed to an instruction held by a stall is honoured when it finally loads.
  always_comb begin
    sel1_nxt = SEL_NONE;
    sel2_nxt = SEL_NONE;
    if (fwd_ex_ex1)                sel1_nxt = SEL_EX;
    else if (fwd_mem_ex1 || pend1) sel1_nxt = SEL_MEM;
    if (fwd_ex_ex2)                sel2_nxt = SEL_EX;
    else if (fwd_mem_ex2 || pend2) sel2_nxt = SEL_MEM;
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0       <= 1'b0;
      rs1_p0       <= '0;
      rs2_p0       <= '0;
      imm_p0       <= '0;
      rd_p0        <= '0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      alu_src_p0   <= 1'b0;
      sel1_p0      <= SEL_NONE;
      sel2_p0      <= SEL_NONE;
      pend1        <= 1'b0;
      pend2        <= 1'b0;
      ex_last      <= '0;
      mem_last     <= '0;
      stall_cnt    <= '0;
      fwd_cnt      <= '0;
    end else begin
      mem_last <= mem_rdata;
      if (vld_p0 && reg_write_p0) ex_last <= ex_result;
      if (flush || stall) begin
        vld_p0       <= 1'b0;
        reg_write_p0 <= 1'b0;
        mem_read_p0  <= 1'b0;
        mem_write_p0 <= 1'b0;
        alu_src_p0   <= 1'b0;
        sel1_p0      <= SEL_NONE;
        sel2_p0      <= SEL_NONE;
        pend1        <= flush ? 1'b0 : (pend1 | fwd_mem_ex1);
        pend2        <= flush ? 1'b0 : (pend2 | fwd_mem_ex2);
        if (!flush) stall_cnt <= sat_inc(stall_cnt);
      end else begin
        vld_p0       <= in_valid;
        rs1_p0       <= in_rs1_data;
        rs2_p0       <= in_rs2_data;
        imm_p0       <= in_imm;
        rd_p0        <= in_rd;
        reg_write_p0 <= in_reg_write;
        mem_read_p0  <= in_mem_read;
        mem_write_p0 <= in_mem_write;
        alu_src_p0   <= in_alu_src;
        sel1_p0      <= sel1_nxt;
        sel2_p0      <= sel2_nxt;
        pend1        <= 1'b0;
        pend2        <= 1'b0;
        if (sel1_nxt != SEL_NONE || sel2_nxt != SEL_NONE) fwd_cnt <= sat_inc(fwd_cnt);
      end
    end
  end

  assign fwd_rs1 = pick(sel1_p0, ex_last, mem_last, rs1_p0);
  assign fwd_rs2 = pick(sel2_p0, ex_last, mem_last, rs2_p0);

  assign op_a          = fwd_rs1;
  assign op_b          = alu_src_p0 ? imm_p0 : fwd_rs2;
  assign store_data    = fwd_rs2;
  assign out_valid     = vld_p0;
  assign out_rd        = rd_p0;
  assign out_reg_write = vld_p0 & reg_write_p0;
  assign out_mem_read  = vld_p0 & mem_read_p0;
  assign out_mem_write = vld_p0 & mem_write_p0;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: a value-level reference model resolves each
// operand at issue time; a monitor compares the DUT outputs cycle by cycle.
module tb_ex_operand_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 0, flush = 0;
  logic fwd_ex_ex1 = 0, fwd_ex_ex2 = 0, fwd_mem_ex1 = 0, fwd_mem_ex2 = 0;
  logic in_valid = 0;
  logic [XLEN-1:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0] in_rd = '0;
  logic in_reg_write = 0, in_mem_read = 0, in_mem_write = 0, in_alu_src = 0;
  logic [XLEN-1:0] ex_result = '0, mem_rdata = '0;
  logic out_valid;
  logic [XLEN-1:0] op_a, op_b, store_data;
  logic [4:0] out_rd;
  logic out_reg_write, out_mem_read, out_mem_write;
  logic [CNT_W-1:0] stall_cnt, fwd_cnt;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .fwd_ex_ex1(fwd_ex_ex1), .fwd_ex_ex2(fwd_ex_ex2),
    .fwd_mem_ex1(fwd_mem_ex1), .fwd_mem_ex2(fwd_mem_ex2),
    .in_valid(in_valid), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_alu_src(in_alu_src),
    .ex_result(ex_result), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .op_a(op_a), .op_b(op_b), .store_data(store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  typedef struct {
    logic v; logic [4:0] rd; logic rw, mr, mw;
    logic [XLEN-1:0] a, b, sd;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: operand values are resolved when the instruction enters EX.
  logic m_v, m_rw, m_mr, m_mw, m_as, m_p1, m_p2;
  logic [4:0] m_rd;
  logic [XLEN-1:0] m_a, m_sd, m_imm, m_exl;
  logic [CNT_W-1:0] m_sc, m_fc;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1;
  endfunction

  task automatic model_reset();
    m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0; m_p1 = 0; m_p2 = 0;
    m_rd = 0; m_a = 0; m_sd = 0; m_imm = 0; m_exl = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    logic [XLEN-1:0] exl_n;
    exp_t e;
    exl_n = (m_v && m_rw) ? ex_result : m_exl;
    if (flush) begin
      m_v = 0; m_p1 = 0; m_p2 = 0;
    end else if (stall) begin
      m_v = 0;
      m_p1 = m_p1 | fwd_mem_ex1;
      m_p2 = m_p2 | fwd_mem_ex2;
      m_sc = sat(m_sc);
    end else begin
      if (fwd_ex_ex1 || fwd_mem_ex1 || m_p1 || fwd_ex_ex2 || fwd_mem_ex2 || m_p2) m_fc = sat(m_fc);
      m_a  = fwd_ex_ex1 ? exl_n : (fwd_mem_ex1 || m_p1) ? mem_rdata : in_rs1_data;
      m_sd = fwd_ex_ex2 ? exl_n : (fwd_mem_ex2 || m_p2) ? mem_rdata : in_rs2_data;
      m_v = in_valid; m_rd = in_rd; m_imm = in_imm; m_as = in_alu_src;
      m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
      m_p1 = 0; m_p2 = 0;
    end
    m_exl = exl_n;
    e.v = m_v; e.rd = m_rd;
    e.rw = m_v & m_rw; e.mr = m_v & m_mr; e.mw = m_v & m_mw;
    e.a = m_a; e.b = m_as ? m_imm : m_sd; e.sd = m_sd;
    e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
  endtask

  // One clock: drive at the falling edge, predict, return shortly after the rising edge.
  task automatic apply(input logic st, input logic fl, input logic iv, input logic [3:0] fw,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                       input logic [XLEN-1:0] im, input logic rw, input logic as,
                       input logic [XLEN-1:0] exr, input logic [XLEN-1:0] mrd);
    @(negedge clk);
    stall = st; flush = fl; in_valid = iv;
    fwd_ex_ex1 = fw[0]; fwd_ex_ex2 = fw[1]; fwd_mem_ex1 = fw[2]; fwd_mem_ex2 = fw[3];
    in_rs1_data = r1; in_rs2_data = r2; in_imm = im; in_rd = 5'($urandom_range(31));
    in_reg_write = rw; in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
    in_alu_src = as; ex_result = exr; mem_rdata = mrd;
    model_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_valid", 32'(out_valid), 32'(e.v));
        check("out_reg_write", 32'(out_reg_write), 32'(e.rw));
        check("out_mem_read", 32'(out_mem_read), 32'(e.mr));
        check("out_mem_write", 32'(out_mem_write), 32'(e.mw));
        check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        check("fwd_cnt", 32'(fwd_cnt), 32'(e.fc));
        if (e.v) begin
          check("out_rd", 32'(out_rd), 32'(e.rd));
          check("op_a", op_a, e.a);
          check("op_b", op_b, e.b);
          check("store_data", store_data, e.sd);
        end
      end
    end
  end

  initial begin : driver
    logic [CNT_W-1:0] snap;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst op_a", op_a, 0);
    check("rst stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk) rst = 1'b1;

    // Plain load, then immediate operand
    apply(0, 0, 1, 4'b0000, 32'h10, 32'h20, 32'h5, 0, 0, 32'h0, 32'h0);
    check("plain op_a", op_a, 32'h10);
    check("plain op_b", op_b, 32'h20);
    check("plain valid", 32'(out_valid), 1);
    apply(0, 0, 1, 4'b0000, 32'h10, 32'h20, 32'h7, 0, 1, 32'h0, 32'h0);
    check("imm op_b", op_b, 32'h7);
    check("imm store_data", store_data, 32'h20);

    // EX forwarding, and EX winning over MEM
    apply(0, 0, 1, 4'b0000, 32'h1, 32'h2, 32'h0, 1, 0, 32'h0, 32'h0);
    apply(0, 0, 1, 4'b0001, 32'h1, 32'h2, 32'h0, 1, 0, 32'hAAAA, 32'h0);
    check("ex fwd op_a", op_a, 32'hAAAA);
    apply(0, 0, 1, 4'b0101, 32'h1, 32'h2, 32'h0, 0, 0, 32'hBBBB, 32'hCCCC);
    check("ex beats mem op_a", op_a, 32'hBBBB);

    // Load-use stall with the MEM forward carried across
    snap = stall_cnt;
    apply(1, 0, 1, 4'b1000, 32'h3, 32'h4, 32'h0, 1, 0, 32'h0, 32'h0);
    check("stall valid", 32'(out_valid), 0);
    check("stall reg_write", 32'(out_reg_write), 0);
    check("stall_cnt inc", 32'(stall_cnt), 32'(snap) + 1);
    apply(0, 0, 1, 4'b0000, 32'h3, 32'h4, 32'h0, 0, 0, 32'h0, 32'h1234);
    check("pend store_data", store_data, 32'h1234);
    check("pend op_b", op_b, 32'h1234);

    // Flush beats stall and drops the pending forward
    apply(1, 0, 1, 4'b1000, 32'h3, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
    snap = stall_cnt;
    apply(1, 1, 1, 4'b1000, 32'h3, 32'h4, 32'h0, 1, 0, 32'h0, 32'h0);
    check("flush valid", 32'(out_valid), 0);
    check("flush stall_cnt", 32'(stall_cnt), 32'(snap));
    apply(0, 0, 1, 4'b0000, 32'h3, 32'h55, 32'h0, 0, 0, 32'h0, 32'h99);
    check("post-flush store_data", store_data, 32'h55);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(3) == 0, $urandom_range(9) == 0, 1'($urandom),
            {$urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0},
            $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
    end

    // Async reset with a valid instruction in EX
    apply(0, 0, 1, 4'b0000, 32'hDEAD, 32'hBEEF, 32'h11, 1, 0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 0);
    check("async rst op_a", op_a, 0);
    check("async rst op_b", op_b, 0);
    check("async rst stall_cnt", 32'(stall_cnt), 0);
    check("async rst fwd_cnt", 32'(fwd_cnt), 0);
    rst = 1'b1;
    model_reset();

    // Reset in the middle of a stall discards the owed forward
    apply(1, 0, 1, 4'b1000, 32'h3, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    apply(0, 0, 1, 4'b0000, 32'h3, 32'h77, 32'h0, 0, 0, 32'h0, 32'h99);
    check("post-rst store_data", store_data, 32'h77);

    // Counter saturation
    for (int i = 0; i < 65540; i++)
      apply(1, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check("stall_cnt saturated", 32'(stall_cnt), 32'hFFFF);

    @(negedge clk);
    stall = 0;
    repeat (2) @(posedge clk);
    #3;
    check("scoreboard drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
